// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first serial receiver with a valid/ready byte output and error pulses.
module uart_rx #(
  parameter int CLK_FREQ = 12_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);
  localparam int DIV  = CLK_FREQ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV + 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_rx: CLK_FREQ/BAUD must be at least 2");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t        state_q, state_d;
  logic          s1_q, rx_s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic          good_q, good_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          accept;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q - CW'(1);
    idx_d       = idx_q;
    sh_d        = sh_q;
    good_d      = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = CW'(HALF - 1);
        if (!rx_s_q) state_d = START;
      end
      START: if (cnt_q == '0) begin
        state_d = rx_s_q ? IDLE : DATA;
        idx_d   = 3'd0;
        cnt_d   = CW'(DIV - 1);
      end
      DATA: if (cnt_q == '0) begin
        sh_d[idx_q] = rx_s_q;
        cnt_d       = CW'(DIV - 1);
        idx_d       = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = STOP;
      end
      STOP: if (cnt_q == '0) begin
        good_d      = rx_s_q;
        frame_err_d = !rx_s_q;
        state_d     = rx_s_q ? IDLE : BRK;
      end
      BRK: if (rx_s_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A finished byte lands if the holding register is empty or is being drained this cycle.
  assign accept    = good_q && (!valid_q || ready);
  assign valid_d   = accept ? 1'b1 : (valid_q && !ready ? 1'b1 : 1'b0);
  assign data_d    = accept ? sh_q : data_q;
  assign overrun_d = good_q && !accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      s1_q        <= 1'b1;
      rx_s_q      <= 1'b1;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      sh_q        <= 8'h00;
      good_q      <= 1'b0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_q        <= rx;
      rx_s_q      <= s1_q;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sh_q        <= sh_d;
      good_q      <= good_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed scenario tests for uart_rx at DIV=10, HALF=5.
module tb_uart_rx;
  localparam int DIV = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid, frame_err, overrun;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [7:0] dq[$];
  int tq[$];
  int vhigh = 0, fe = 0, ov = 0;

  uart_rx #(.CLK_FREQ(1_000_000), .BAUD(100_000)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data(data), .valid(valid),
    .ready(ready), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change on negedge; sample just after so the values match what the next posedge sees.
  always @(negedge clk) begin
    #1;
    if (valid) vhigh++;
    if (valid && ready) begin
      dq.push_back(data);
      tq.push_back(cyc);
    end
    if (frame_err) fe++;
    if (overrun) ov++;
  end

  task automatic clear();
    dq.delete();
    tq.delete();
    vhigh = 0;
    fe = 0;
    ov = 0;
  endtask

  task automatic send(input logic [7:0] b, input logic stop, output int t);
    rx = 1'b0;
    t = cyc;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = stop;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #2;
    vectors++;
    if ({valid, data, frame_err, overrun} !== 11'h0) begin
      miscompares++;
      $display("FAIL reset: valid=%b data=%h fe=%b ov=%b, want all 0", valid, data, frame_err, overrun);
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    int t;
    clear();
    ready = 1'b1;
    send(8'h55, 1'b1, t);
    repeat (5) @(negedge clk);
    vectors++;
    if (dq.size() !== 1) begin
      miscompares++;
      $display("FAIL single_count: got %0d bytes, want 1", dq.size());
    end else begin
      vectors += 2;
      if (dq[0] !== 8'h55) begin
        miscompares++;
        $display("FAIL single_data: got %h, want 55", dq[0]);
      end
      if (tq[0] !== t + 99) begin
        miscompares++;
        $display("FAIL single_latency: valid at edge %0d, want 98", tq[0] - t - 1);
      end
    end
    vectors += 2;
    if (vhigh !== 1) begin
      miscompares++;
      $display("FAIL single_width: valid high %0d cycles, want 1", vhigh);
    end
    if (fe !== 0 || ov !== 0) begin
      miscompares++;
      $display("FAIL single_pulses: fe=%0d ov=%0d, want 0 0", fe, ov);
    end
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    clear();
    send(8'hA3, 1'b1, t1);
    send(8'h0F, 1'b1, t2);
    repeat (5) @(negedge clk);
    vectors++;
    if (dq.size() !== 2) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d bytes, want 2", dq.size());
    end else begin
      vectors += 3;
      if (dq[0] !== 8'hA3 || dq[1] !== 8'h0F) begin
        miscompares++;
        $display("FAIL b2b_data: got %h %h, want a3 0f", dq[0], dq[1]);
      end
      if (tq[1] - tq[0] !== 100) begin
        miscompares++;
        $display("FAIL b2b_spacing: got %0d cycles, want 100", tq[1] - tq[0]);
      end
      if (tq[0] !== t1 + 99) begin
        miscompares++;
        $display("FAIL b2b_latency: first valid at edge %0d, want 98", tq[0] - t1 - 1);
      end
    end
    vectors++;
    if (vhigh !== 2) begin
      miscompares++;
      $display("FAIL b2b_width: valid high %0d cycles, want 2", vhigh);
    end
  endtask

  task automatic test_overrun();
    int t;
    clear();
    ready = 1'b0;
    send(8'h11, 1'b1, t);
    send(8'h22, 1'b1, t);
    repeat (5) @(negedge clk);
    vectors += 3;
    if (valid !== 1'b1 || data !== 8'h11) begin
      miscompares++;
      $display("FAIL ovr_hold: valid=%b data=%h, want 1 11", valid, data);
    end
    if (ov !== 1) begin
      miscompares++;
      $display("FAIL ovr_pulse: got %0d overrun pulses, want 1", ov);
    end
    if (fe !== 0) begin
      miscompares++;
      $display("FAIL ovr_fe: got %0d frame errors, want 0", fe);
    end
    ready = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    vectors += 2;
    if (dq.size() !== 1 || dq[0] !== 8'h11) begin
      miscompares++;
      $display("FAIL ovr_drain: got %0d bytes first=%h, want 1 byte 11", dq.size(), dq.size() ? dq[0] : 8'hxx);
    end
    if (valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ovr_clear: valid=%b, want 0", valid);
    end
    @(negedge clk);
  endtask

  task automatic test_frame_err();
    int t;
    clear();
    send(8'h7E, 1'b0, t);
    rx = 1'b0;
    repeat (50) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    vectors += 2;
    if (fe !== 1) begin
      miscompares++;
      $display("FAIL ferr_pulse: got %0d frame errors, want 1", fe);
    end
    if (dq.size() !== 0 || vhigh !== 0) begin
      miscompares++;
      $display("FAIL ferr_novalid: got %0d bytes %0d valid cycles, want 0 0", dq.size(), vhigh);
    end
    send(8'h42, 1'b1, t);
    repeat (5) @(negedge clk);
    vectors += 2;
    if (dq.size() !== 1 || dq[0] !== 8'h42) begin
      miscompares++;
      $display("FAIL ferr_next: got %0d bytes first=%h, want 1 byte 42", dq.size(), dq.size() ? dq[0] : 8'hxx);
    end
    if (fe !== 1 || ov !== 0) begin
      miscompares++;
      $display("FAIL ferr_after: fe=%0d ov=%0d, want 1 0", fe, ov);
    end
  endtask

  task automatic test_glitch();
    int t;
    clear();
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (120) @(negedge clk);
    vectors++;
    if (vhigh !== 0 || fe !== 0 || ov !== 0) begin
      miscompares++;
      $display("FAIL glitch_quiet: valid=%0d fe=%0d ov=%0d, want 0 0 0", vhigh, fe, ov);
    end
    send(8'h99, 1'b1, t);
    repeat (5) @(negedge clk);
    vectors += 2;
    if (dq.size() !== 1 || dq[0] !== 8'h99) begin
      miscompares++;
      $display("FAIL glitch_next: got %0d bytes first=%h, want 1 byte 99", dq.size(), dq.size() ? dq[0] : 8'hxx);
    end
    if (dq.size() == 1 && tq[0] !== t + 99) begin
      miscompares++;
      $display("FAIL glitch_latency: valid at edge %0d, want 98", tq[0] - t - 1);
    end
  endtask

  task automatic test_mid_reset();
    int t;
    logic [7:0] b;
    clear();
    b = 8'hF0;
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = b[4];
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    vectors++;
    if ({valid, data, frame_err, overrun} !== 11'h0) begin
      miscompares++;
      $display("FAIL rst_outputs: valid=%b data=%h fe=%b ov=%b, want all 0", valid, data, frame_err, overrun);
    end
    repeat (4 + 3 * DIV + DIV + 20) @(negedge clk);
    vectors++;
    if (dq.size() !== 0 || vhigh !== 0 || fe !== 0 || ov !== 0) begin
      miscompares++;
      $display("FAIL rst_abort: bytes=%0d valid=%0d fe=%0d ov=%0d, want 0", dq.size(), vhigh, fe, ov);
    end
    send(8'h3C, 1'b1, t);
    repeat (5) @(negedge clk);
    vectors++;
    if (dq.size() !== 1 || dq[0] !== 8'h3C) begin
      miscompares++;
      $display("FAIL rst_next: got %0d bytes first=%h, want 1 byte 3c", dq.size(), dq.size() ? dq[0] : 8'hxx);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Asynchronous serial receiver (8N1, LSB first). It is the consumer of the serial line produced by the existing transmitter. It samples a raw rx pin, rebuilds bytes, and presents them on a valid/ready byte interface with the same handshake polarity the transmitter uses on its input. Used for loopback test tops and as the command input path.

Parameters:
CLK_FREQ, 12_000_000, system clock frequency in Hz.
BAUD, 115_200, line bit rate.
DIV, CLK_FREQ/BAUD (integer truncation), clocks per bit (derived localparam, not overridable).
HALF, DIV/2 (truncated), clocks to mid start bit (derived localparam).

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
rx  input  1  raw serial line; asynchronous to clk; idle high.
data  output  8  received byte; valid only while valid=1.
valid  output  1  byte available.
ready  input  1  consumer accepts byte when valid&&ready at a rising edge.
frame_err  output  1  one-cycle pulse: stop bit sampled low.
overrun  output  1  one-cycle pulse: good byte dropped because previous byte not yet taken.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high. Reset values: state=IDLE, valid=0, data=8'h00, frame_err=0, overrun=0, both synchronizer flops=1, counters=0.
- rx passes through a 2-flop synchronizer, giving rx_s. All decisions use rx_s only.
- Bit counter: cnt counts down per state. The bit index runs 0..7.
- IDLE: when rx_s==0, load cnt=HALF-1 and go to START.
- START: decrement cnt. At cnt==0, sample rx_s:
  - 1 → glitch; return to IDLE. No output activity.
  - 0 → go to DATA, idx=0, cnt=DIV-1.
- DATA: at cnt==0, sample rx_s into data shift register bit idx (LSB first) and reload cnt=DIV-1. After idx==7 is sampled, go to STOP.
- STOP: at cnt==0, sample rx_s:
  - 1 → good frame. Deliver the byte per the output rules below, then go to IDLE in the same cycle (back-to-back frames accepted; no wait for the end of the stop bit).
  - 0 → frame_err=1 for one cycle, byte discarded, go to BREAK.
- BREAK: stay until rx_s==1, then IDLE. This prevents a held-low line from being read as repeated 0x00 bytes.
- Output register: on a good frame, the next edge sets valid=1 and data=the new byte if either (a) valid==0, or (b) valid&&ready in that same cycle. In (b) valid stays high with no gap and no overrun.
- Otherwise the new byte is dropped, data/valid are unchanged, and overrun pulses for one cycle.
- valid clears on the edge where valid&&ready and no new byte lands. data holds while valid=1. ready is ignored while valid=0.
- Latency: call edge 0 the edge on which the first synchronizer flop captures rx=0. valid rises on edge 2+HALF+9*DIV+1 (98 for DIV=10, HALF=5).
- rst asserted mid-frame aborts the frame: no valid and no pulses. The receiver restarts on the next falling edge after rst deasserts.
- DIV<2 is illegal; synthesis-time assertion.

Test Plan:
1. Bench uses CLK_FREQ=1_000_000, BAUD=100_000 (DIV=10, HALF=5). Send 0x55 with ready=1 → valid high for exactly 1 cycle at edge 98, data=8'h55, frame_err=0, overrun=0.
2. Send 0xA3 then 0x0F back-to-back (stop bit exactly DIV) with ready=1 → two single-cycle valids, 100 cycles apart, with data 0xA3 then 0x0F.
3. Hold ready=0 and send 0x11 then 0x22 → data stays 0x11, valid stays 1, one overrun pulse at the second stop sample. Then raise ready → one transfer of 0x11, then valid=0.
4. Send 0x7E with the stop bit forced low, then hold rx low for 50 cycles, then high, then send 0x42 → one frame_err pulse, no valid for 0x7E or during the low period, then 0x42 received correctly.
5. Drive rx low for 3 cycles (shorter than HALF) → no state exit from IDLE after START; no valid and no error pulses. A following 0x99 is received correctly.
6. Assert rst for 1 cycle during data bit 4 of 0xF0 → no valid or pulses for that frame, all outputs at reset values. Then 0x3C is received correctly.
